aui_lane_scheduler: RTL and testbench
=====================================

AUI_LANE_SCHEDULER -- requirements
Module: aui_lane_scheduler

Interface
- REQ-001 Parameter DATA_WIDTH, default 64, width of input word and of each lane word.
- REQ-002 Parameter NUMBER_LANES, default 16, number of transmit lanes; power of two, 2..16.
- REQ-003 Parameter AM_PERIOD, default 1024, number of complete data rounds between alignment-marker rounds; must be at least 1.
- REQ-004 Parameter AM_BASE, default 64'hC168_21F4_3E97_DE0B, marker seed; lane k marker = AM_BASE XOR k (k zero-extended).
- REQ-005 clk  input  1  single clock; all state updates on its rising edge.
- REQ-006 rst_n  input  1  reset, asynchronous, active-low.
- REQ-007 i_enable  input  1  level; permits the scheduler to leave IDLE.
- REQ-008 i_data  input  DATA_WIDTH  input word.
- REQ-009 i_valid  input  1  i_data is valid.
- REQ-010 o_ready  output  1  scheduler accepts i_data this cycle.
- REQ-011 tx_lane  output  DATA_WIDTH x NUMBER_LANES (unpacked array)  registered lane words.
- REQ-012 o_lane_strobe  output  NUMBER_LANES  one-hot; bit k high for one cycle when tx_lane[k] has just been updated.
- REQ-013 o_am_active  output  1  high during every cycle of a marker round.

Function
- REQ-014 FSM states: IDLE, DATA, AM.
- REQ-015 IDLE: o_ready=0; lane_ptr=0; moves to DATA on the cycle after i_enable=1.
- REQ-016 DATA: o_ready=1; a word transfers when i_valid and o_ready are both high on a clock edge.
- REQ-017 An accepted word is written to tx_lane[lane_ptr], and o_lane_strobe bit lane_ptr is set; both are visible on the next cycle (1-cycle latency).
- REQ-018 lane_ptr increments on each accepted word and wraps from NUMBER_LANES-1 to 0; i_valid=0 stalls lane_ptr with no strobe.
- REQ-019 At each wrap, round_cnt increments. When round_cnt equals AM_PERIOD-1 at a wrap, round_cnt clears to 0 and the FSM enters AM.
- REQ-020 AM: o_ready=0 and o_am_active=1 for exactly NUMBER_LANES cycles. On each cycle the marker for lane lane_ptr is written to that lane, and its strobe is set. lane_ptr counts 0..NUMBER_LANES-1; i_valid is ignored. After the last lane the FSM returns to DATA with lane_ptr=0.
- REQ-021 If i_enable=0 in DATA, the FSM goes to IDLE only when lane_ptr==0 and no word is accepted that cycle. A partial round always completes.
- REQ-022 i_enable is ignored in AM. The AM round always completes; its exit state is IDLE if i_enable=0 at exit, else DATA.
- REQ-023 tx_lane[k] holds its last value between updates. At most one strobe bit is high per cycle.
- REQ-024 round_cnt has width clog2(AM_PERIOD)+1 and holds its value in IDLE.

Reset
- REQ-025 rst_n=0 forces, asynchronously: state IDLE, lane_ptr 0, round_cnt 0, all tx_lane 0, o_lane_strobe 0, o_am_active 0, o_ready 0.
- REQ-026 Reset asserted mid-round or mid-AM discards the partial round. After release, operation restarts from lane 0 with round_cnt 0.

Configuration
- REQ-027 Macro AUI_AM_INSERT_EN is defined: marker insertion operates per REQ-019/020/022.
- REQ-028 Macro AUI_AM_INSERT_EN is undefined: the AM state and round_cnt are absent, o_am_active is tied 0, and DATA runs continuously with wrap only.

Verification
- REQ-029 Reset release with i_enable=1 and i_valid=1 constant, i_data = 0,1,2,... → first accepted word lands in tx_lane[0] with strobe 16'h0001; word 17 lands in tx_lane[0] with strobe 16'h0001 again.
- REQ-030 i_valid toggles 1,0,1 in DATA → lane_ptr advances only on accepted beats; no strobe on the idle cycle; tx_lane values are unchanged.
- REQ-031 AM_PERIOD=2, macro defined, continuous valid → after 32 words, 16 cycles with o_ready=0 and o_am_active=1; tx_lane[5] = AM_BASE^5; next word goes to tx_lane[0].
- REQ-032 i_enable dropped after word 7 of a round → words 8..15 are still accepted; then IDLE with o_ready=0; re-enable resumes at lane 0.
- REQ-033 rst_n pulsed low during AM cycle 4 → all outputs are 0 immediately; after release the first word goes to lane 0; the next AM occurs after a full AM_PERIOD.
- REQ-034 Macro undefined, AM_PERIOD=2, 64 continuous words → o_am_active is never 1 and o_ready is never deasserted while enabled.

Source files
------------

// File: rtl/aui_lane_scheduler.sv
// Purpose: stripes an input word stream round-robin over NUMBER_LANES registered lanes; AUI_AM_INSERT_EN adds a marker round every AM_PERIOD data rounds.
// Latency: one cycle from an accepted word (or marker slot) to tx_lane/o_lane_strobe.
// Backpressure: o_ready is low in IDLE, during marker rounds, and at a round boundary once i_enable has dropped.
module aui_lane_scheduler #(
    parameter int unsigned           DATA_WIDTH   = 64,
    parameter int unsigned           NUMBER_LANES = 16,
    parameter int unsigned           AM_PERIOD    = 1024,
    parameter logic [DATA_WIDTH-1:0] AM_BASE      = 64'hC168_21F4_3E97_DE0B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [DATA_WIDTH-1:0]   tx_lane [NUMBER_LANES],
    output logic [NUMBER_LANES-1:0] o_lane_strobe,
    output logic                    o_am_active
);
    localparam int unsigned   LW        = $clog2(NUMBER_LANES);
    localparam logic [LW-1:0] LANE_LAST = LW'(NUMBER_LANES - 1);

`ifdef AUI_AM_INSERT_EN
    typedef enum logic [1:0] {IDLE, DATA, AM} state_t;
    localparam int unsigned   RW         = $clog2(AM_PERIOD) + 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(AM_PERIOD - 1);
    logic [RW-1:0] round_cnt, round_cnt_nxt;
`else
    typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

    state_t                  state, state_nxt;
    logic [LW-1:0]           lane_ptr, lane_ptr_nxt;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_dat;
    logic                    accept;

    always_comb begin
        state_nxt    = state;
        lane_ptr_nxt = lane_ptr;
        wr_en        = 1'b0;
        wr_dat       = i_data;
        accept       = 1'b0;
        o_ready      = 1'b0;
        o_am_active  = 1'b0;
`ifdef AUI_AM_INSERT_EN
        round_cnt_nxt = round_cnt;
`endif
        case (state)
            IDLE: begin
                lane_ptr_nxt = '0;
                if (i_enable) state_nxt = DATA;
            end
            DATA: begin
                // A dropped enable only stops traffic at a round boundary; partial rounds drain.
                o_ready = i_enable || (lane_ptr != '0);
                accept  = o_ready && i_valid;
                if (accept) begin
                    wr_en        = 1'b1;
                    lane_ptr_nxt = lane_ptr + LW'(1);
`ifdef AUI_AM_INSERT_EN
                    if (lane_ptr == LANE_LAST) begin
                        if (round_cnt == ROUND_LAST) begin
                            round_cnt_nxt = '0;
                            state_nxt     = AM;
                        end else begin
                            round_cnt_nxt = round_cnt + RW'(1);
                        end
                    end
`endif
                end else if (!i_enable && (lane_ptr == '0)) begin
                    state_nxt = IDLE;
                end
            end
`ifdef AUI_AM_INSERT_EN
            AM: begin
                o_am_active  = 1'b1;
                wr_en        = 1'b1;
                wr_dat       = AM_BASE ^ DATA_WIDTH'(lane_ptr);
                lane_ptr_nxt = lane_ptr + LW'(1);
                if (lane_ptr == LANE_LAST) state_nxt = i_enable ? DATA : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lane_ptr      <= '0;
            o_lane_strobe <= '0;
            for (int k = 0; k < NUMBER_LANES; k++) tx_lane[k] <= '0;
`ifdef AUI_AM_INSERT_EN
            round_cnt     <= '0;
`endif
        end else begin
            state         <= state_nxt;
            lane_ptr      <= lane_ptr_nxt;
            o_lane_strobe <= '0;
            if (wr_en) begin
                tx_lane[lane_ptr]       <= wr_dat;
                o_lane_strobe[lane_ptr] <= 1'b1;
            end
`ifdef AUI_AM_INSERT_EN
            round_cnt     <= round_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_aui_lane_scheduler.sv
// Bench for aui_lane_scheduler: random traffic against a round-robin lane model, expected lane writes queued and popped by a monitor.
module tb_aui_lane_scheduler;
    localparam int DW  = 64;
    localparam int N   = 16;
    localparam int AMP = 2;
    localparam logic [DW-1:0] BASE = 64'hC168_21F4_3E97_DE0B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_enable;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] tx_lane [N];
    logic [N-1:0]  o_lane_strobe;
    logic          o_am_active;

    aui_lane_scheduler #(
        .DATA_WIDTH(DW), .NUMBER_LANES(N), .AM_PERIOD(AMP), .AM_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .tx_lane(tx_lane),
        .o_lane_strobe(o_lane_strobe), .o_am_active(o_am_active)
    );

    always #5 clk = ~clk;

    typedef struct { int lane; logic [DW-1:0] val; } exp_t;
    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] shadow [N];
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int acc = 0, rounds = 0, stalls = 0, am_run = 0, am_seen = 0;
    int r0, exp_st, got;
    bit took, seen;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Model: word i goes to lane i mod N; every AMP-th completed round is followed by N markers.
    task automatic push_word(input logic [DW-1:0] d);
        exp_q.push_back('{acc % N, d});
        acc++;
        if (acc % N == 0) begin
            rounds++;
`ifdef AUI_AM_INSERT_EN
            if (rounds % AMP == 0)
                for (int k = 0; k < N; k++) exp_q.push_back('{k, BASE ^ DW'(k)});
`endif
        end
    endtask

    task automatic cycle(input bit v, output bit tk);
        @(negedge clk);
        i_valid = v;
        i_data  = {$urandom, $urandom};
        #1;
        tk = o_ready && i_valid;
        if (tk) push_word(i_data);
    endtask

    task automatic run_words(input int n, input int pct, input int budget);
        int  g = 0;
        bit  t;
        for (int c = 0; c < budget && g < n; c++) begin
            cycle($urandom_range(99) < pct, t);
            if (t) g++;
            else if (i_valid && g > 0) stalls++;
        end
        check("words_accepted", g, n);
    endtask

    task automatic align(input int target);
        int k = (target - acc % N + N) % N;
        if (k > 0) run_words(k, 100, 3 * k + 40);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [DW-1:0] any = '0;
        for (int k = 0; k < N; k++) any |= tx_lane[k];
        check({tag, "_ready"},  o_ready, 0);
        check({tag, "_am"},     o_am_active, 0);
        check({tag, "_strobe"}, o_lane_strobe, 0);
        check({tag, "_lanes"},  any, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) shadow[k] = '0;
            am_run = 0;
        end else begin
            if (o_lane_strobe != '0) begin
                if (exp_q.size() == 0) check("unexpected_strobe", o_lane_strobe, 0);
                else begin
                    e = exp_q.pop_front();
                    check("strobe", o_lane_strobe, N'(1) << e.lane);
                    shadow[e.lane] = e.val;
                end
            end else begin
                check("missing_strobe", exp_q.size(), 0);
            end
            begin
                int bad = -1;
                for (int k = 0; k < N; k++)
                    if (tx_lane[k] !== shadow[k] && bad < 0) bad = k;
                n_checks++;
                if (bad < 0) n_pass++;
                else begin
                    n_fail++;
                    $display("FAIL lane_%0d: got %h expected %h", bad, tx_lane[bad], shadow[bad]);
                end
            end
            if (o_am_active) begin
                am_run++;
                am_seen++;
                check("ready_low_in_am", o_ready, 0);
            end else if (am_run != 0) begin
                check("am_len", am_run, N);
                am_run = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_data = '0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        i_enable = 1'b1;

        run_words(17, 100, 80);
        run_words(40, 50, 400);

        align(0);
        r0 = rounds;
        exp_st = 0;
`ifdef AUI_AM_INSERT_EN
        for (int r = r0 + 1; r <= r0 + 3; r++) if (r % AMP == 0) exp_st += N;
`endif
        stalls = 0;
        run_words(64, 100, 300);
        check("stall_cycles_64w", stalls, exp_st);

        align(8);
        i_enable = 1'b0;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            cycle(1'b1, took);
            if (took) got++;
        end
        check("drain_after_disable", got, 8);
        check("idle_ready", o_ready, 0);
        i_enable = 1'b1;
        run_words(20, 100, 100);

`ifdef AUI_AM_INSERT_EN
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            cycle(1'b1, took);
            seen = o_am_active;
        end
        check("am_reached", seen, 1);
        repeat (3) cycle(1'b1, took);
`else
        align(5);
`endif
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        acc = 0;
        rounds = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        run_words(N * AMP + 5, 100, 200);
        run_words(30, 70, 300);

        for (int c = 0; c < N + 4; c++) cycle(1'b0, took);
        check("queue_drained", exp_q.size(), 0);
`ifdef AUI_AM_INSERT_EN
        check("am_observed", am_seen > 0, 1);
`else
        check("am_never", am_seen, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
